memio_access_ctrl: RTL and testbench

// Multi-cycle load/store sequencer between the execute stage and the data-memory / I/O buses.

---
 rtl/memio_pkg.sv | 14 +
 rtl/memio_region_dec.sv | 21 ++
 rtl/memio_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_memio_access_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memio_pkg.sv
// Shared state encoding and default parameters for the load/store sequencer.
package memio_pkg;

   typedef enum logic [1:0] {IDLE, MEM, IO, RESP} state_t;

   localparam logic [21:0] DEF_IO_HI = 22'h3FFFFF;
   localparam int          DEF_N_CH  = 4;
   localparam int          CH_W      = $clog2(DEF_N_CH);

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/memio_region_dec.sv
// Address region decode: flags the I/O window and extracts the channel select field.
module memio_region_dec #(
   parameter int              HI_W   = 22,
   parameter logic [HI_W-1:0] IO_HI  = '1,
   parameter int              N_CH   = 4,
   parameter int              CH_LSB = 2,
   parameter int              SEL_W  = $clog2(N_CH)
) (
   input  logic [31:0]      addr,
   output logic             is_io,
   output logic [SEL_W-1:0] ch
);

   // Only the high field and the channel field matter; the rest is folded away.
   logic addr_unused;

   assign is_io       = (addr[31 -: HI_W] == IO_HI);
   assign ch          = addr[CH_LSB +: SEL_W];
   assign addr_unused = ^addr;

endmodule

// File: rtl/memio_access_ctrl.sv
// Load/store sequencer: steers each accepted lw/sw to data memory or one of N_CH I/O
// channels and holds the pipeline until the access completes or times out.
module memio_access_ctrl
   import memio_pkg::*;
#(
   parameter int              DATA_W  = 32,
   parameter int              HI_W    = 22,
   parameter logic [HI_W-1:0] IO_HI   = DEF_IO_HI,
   parameter int              N_CH    = DEF_N_CH,
   parameter int              CH_LSB  = 2,
   parameter int              MEM_LAT = 1,
   parameter int              TMO     = 15
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req_valid,
   input  logic                   req_we,
   input  logic [31:0]            req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   req_ready,
   output logic                   stall,
   output logic                   rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic                   mem_to_reg,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic [31:0]            mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic [N_CH-1:0]        io_read,
   output logic [N_CH-1:0]        io_write,
   output logic [31:0]            io_addr,
   output logic [DATA_W-1:0]      io_wdata,
   input  logic [N_CH*DATA_W-1:0] io_rdata,
   input  logic [N_CH-1:0]        io_ready,
   output state_t                 dbg_state
);

   localparam int SEL_W = $clog2(N_CH);
   localparam int CNT_W = $clog2(max_int(MEM_LAT, TMO) + 1);

   logic              dec_is_io;
   logic [SEL_W-1:0]  dec_ch;
   logic [N_CH-1:0]   dec_oh;
   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic [SEL_W-1:0]  ch_q;
   logic [DATA_W-1:0] io_sel_data;

   memio_region_dec #(
      .HI_W   (HI_W),
      .IO_HI  (IO_HI),
      .N_CH   (N_CH),
      .CH_LSB (CH_LSB)
   ) u_dec (
      .addr  (req_addr),
      .is_io (dec_is_io),
      .ch    (dec_ch)
   );

   assign dec_oh      = {{(N_CH-1){1'b0}}, 1'b1} << dec_ch;
   assign io_sel_data = io_rdata[int'(ch_q)*DATA_W +: DATA_W];

   // req_valid/req_ready: a request transfers on a cycle where both are high. req_ready
   // is high only in IDLE; dropping req_valid while busy has no effect on the latched access.
   assign stall     = req_valid & ~req_ready;
   assign mem_addr  = addr_q;
   assign io_addr   = addr_q;
   assign mem_wdata = wdata_q;
   assign io_wdata  = wdata_q;
   assign dbg_state = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         mem_to_reg <= 1'b0;
         rsp_rdata  <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         io_read    <= '0;
         io_write   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         ch_q       <= '0;
         cnt        <= '0;
      end else begin
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         mem_to_reg <= 1'b0;
         rsp_rdata  <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  we_q      <= req_we;
                  ch_q      <= dec_ch;
                  req_ready <= 1'b0;
                  cnt       <= '0;
                  if (dec_is_io) begin
                     state    <= IO;
                     io_read  <= req_we ? '0 : dec_oh;
                     io_write <= req_we ? dec_oh : '0;
                  end else begin
                     state     <= MEM;
                     mem_read  <= ~req_we;
                     mem_write <= req_we;
                  end
               end
            end
            MEM: begin
               cnt <= cnt + 1'b1;
               // Stores take a single cycle; loads wait out the memory latency.
               if (we_q || cnt == CNT_W'(MEM_LAT - 1)) begin
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  state      <= RESP;
                  cnt        <= '0;
                  rsp_valid  <= 1'b1;
                  mem_to_reg <= ~we_q;
                  rsp_rdata  <= we_q ? '0 : mem_rdata;
               end
            end
            IO: begin
               cnt <= cnt + 1'b1;
               // Ready is tested first so it wins over a same-cycle timeout.
               if (io_ready[ch_q] || cnt == CNT_W'(TMO - 1)) begin
                  io_read    <= '0;
                  io_write   <= '0;
                  state      <= RESP;
                  cnt        <= '0;
                  rsp_valid  <= 1'b1;
                  mem_to_reg <= ~we_q;
                  rsp_err    <= ~io_ready[ch_q];
                  rsp_rdata  <= (we_q || !io_ready[ch_q]) ? '0 : io_sel_data;
               end
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               cnt       <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memio_access_ctrl.sv
// Bench for memio_access_ctrl: directed lw/sw cases and a random stream checked against
// a behavioural model of memory contents, I/O channel replies and response timing.
module tb_memio_access_ctrl;
   import memio_pkg::*;

   localparam int              DATA_W  = 32;
   localparam int              HI_W    = 22;
   localparam logic [HI_W-1:0] IO_HI   = 22'h3FFFFF;
   localparam int              N_CH    = 4;
   localparam int              CH_LSB  = 2;
   localparam int              MEM_LAT = 1;
   localparam int              TMO     = 15;
   localparam int              RW      = DATA_W + 2;
   localparam int              SW      = 2 + 2*N_CH;
   localparam int              NEVER   = TMO + 10;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   req_valid, req_we;
   logic [31:0]            req_addr;
   logic [DATA_W-1:0]      req_wdata;
   logic                   req_ready, stall, rsp_valid, rsp_err, mem_to_reg;
   logic [DATA_W-1:0]      rsp_rdata;
   logic                   mem_read, mem_write;
   logic [31:0]            mem_addr, io_addr;
   logic [DATA_W-1:0]      mem_wdata, mem_rdata, io_wdata;
   logic [N_CH-1:0]        io_read, io_write, io_ready;
   logic [N_CH*DATA_W-1:0] io_rdata;
   state_t                 dbg_state;

   typedef struct {
      logic [SW-1:0]     strobes;
      logic [31:0]       addr;
      logic [DATA_W-1:0] wdata;
      logic              we;
      logic              is_mem;
      int                lat;
   } acc_t;

   logic [RW-1:0]     exp_q[$];
   acc_t              acc_q[$];
   int                plan_wait_q[$];
   logic [DATA_W-1:0] plan_data_q[$];
   logic [DATA_W-1:0] ref_mem[logic [31:0]];
   logic [DATA_W-1:0] env_mem[logic [31:0]];
   logic [31:0]       pool[8] = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0080, 32'h0000_1000,
                                  32'h8000_1000, 32'hFFFF_FBFC, 32'h0000_0000, 32'h7FFF_FFFC};
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   memio_access_ctrl #(
      .DATA_W(DATA_W), .HI_W(HI_W), .IO_HI(IO_HI), .N_CH(N_CH),
      .CH_LSB(CH_LSB), .MEM_LAT(MEM_LAT), .TMO(TMO)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .stall(stall),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_to_reg(mem_to_reg),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .io_read(io_read), .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_ready(io_ready),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : DATA_W'(a ^ 32'h5A5A_C3C3);
   endfunction

   function automatic logic [DATA_W-1:0] env_rd(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : DATA_W'(a ^ 32'h5A5A_C3C3);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   // Caller is at posedge+2. Pushes expectations, presents the request, returns at
   // posedge+2 after the accepting edge; hold keeps req_valid up for a follow-on request.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [DATA_W-1:0] wdata,
                        input int wait_c, input logic hold);
      acc_t              a;
      logic              is_io;
      int                ch;
      logic [N_CH-1:0]   oh;
      logic [DATA_W-1:0] iod;
      logic [RW-1:0]     e;
      logic              accepted;
      int                n;
      is_io    = ((addr >> (32 - HI_W)) == 32'(IO_HI));
      ch       = int'((addr >> CH_LSB) % N_CH);
      oh       = N_CH'(1) << ch;
      a.addr   = addr;
      a.wdata  = wdata;
      a.we     = we;
      a.is_mem = !is_io;
      if (!is_io) begin
         a.strobes = {~we, we, {(2*N_CH){1'b0}}};
         a.lat     = we ? 2 : 1 + MEM_LAT;
         if (we) begin
            ref_mem[addr] = wdata;
            e = '0;
         end else begin
            e = {1'b0, 1'b1, ref_rd(addr)};
         end
      end else begin
         a.strobes = {2'b00, (we ? {N_CH{1'b0}} : oh), (we ? oh : {N_CH{1'b0}})};
         iod = DATA_W'($urandom());
         plan_wait_q.push_back(wait_c);
         plan_data_q.push_back(iod);
         if (wait_c <= TMO) begin
            a.lat = 1 + wait_c;
            e     = {1'b0, ~we, (we ? {DATA_W{1'b0}} : iod)};
         end else begin
            a.lat = 1 + TMO;
            e     = {1'b1, ~we, {DATA_W{1'b0}}};
         end
      end
      acc_q.push_back(a);
      exp_q.push_back(e);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      accepted  = 1'b0;
      n         = 0;
      while (!accepted && n < 100) begin
         @(negedge clock);
         if (req_ready) accepted = 1'b1;
         n++;
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready low for %0d cycles, required 1", n);
      end
      @(posedge clock);
      #2;
      if (!hold) begin
         req_valid = 1'b0;
         req_we    = 1'($urandom());
         req_addr  = $urandom();
         req_wdata = DATA_W'($urandom());
      end
   endtask

   // ---------------- memory and I/O responders ----------------
   initial begin : responders
      int                rd_cnt = 0;
      int                io_cnt = 0;
      int                cur_wait = 0;
      int                idx = 0;
      logic [DATA_W-1:0] cur_data = '0;
      logic [N_CH-1:0]   sel;
      mem_rdata = '0;
      io_rdata  = '0;
      io_ready  = '0;
      forever begin
         @(posedge clock);
         #2;
         if (mem_read) begin
            rd_cnt++;
            mem_rdata = (rd_cnt == MEM_LAT) ? env_rd(mem_addr) : DATA_W'($urandom());
         end else begin
            rd_cnt    = 0;
            mem_rdata = DATA_W'($urandom());
         end
         if (mem_write) env_mem[mem_addr] = mem_wdata;
         for (int c = 0; c < N_CH; c++) io_rdata[c*DATA_W +: DATA_W] = DATA_W'($urandom());
         sel = io_read | io_write;
         if (sel != '0 && !reset) begin
            if (io_cnt == 0) begin
               if (plan_wait_q.size() != 0) begin
                  cur_wait = plan_wait_q.pop_front();
                  cur_data = plan_data_q.pop_front();
               end else begin
                  cur_wait = NEVER;
               end
            end
            io_cnt++;
            for (int c = 0; c < N_CH; c++) if (sel[c]) idx = c;
            io_ready = N_CH'($urandom()) & ~sel;
            if (io_cnt == cur_wait) begin
               io_ready = io_ready | sel;
               io_rdata[idx*DATA_W +: DATA_W] = cur_data;
            end
         end else begin
            io_cnt   = 0;
            io_ready = N_CH'($urandom());
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic          in_flight = 1'b0;
      acc_t          cur;
      int            acc_cyc = 0;
      logic [SW-1:0] strb;
      logic [RW-1:0] e;
      forever begin
         @(negedge clock);
         cyc++;
         strb = {mem_read, mem_write, io_read, io_write};
         if (reset) begin
            in_flight = 1'b0;
            exp_q.delete();
            acc_q.delete();
            plan_wait_q.delete();
            plan_data_q.delete();
         end else begin
            check("strobe_onehot", 64'($countones(strb) <= 1), 64'(1));
            check("req_ready", 64'(req_ready), 64'(!in_flight));
            check("stall", 64'(stall), 64'(req_valid && in_flight));
            if (in_flight) begin
               if (!rsp_valid) begin
                  check("strobes", 64'(strb), 64'(cur.strobes));
                  check("bus_addr", 64'(cur.is_mem ? mem_addr : io_addr), 64'(cur.addr));
                  if (cur.we)
                     check("bus_wdata", 64'(cur.is_mem ? mem_wdata : io_wdata), 64'(cur.wdata));
                  if (cyc - acc_cyc > cur.lat) begin
                     check("rsp_late", 64'(cyc - acc_cyc), 64'(cur.lat));
                     in_flight = 1'b0;
                     if (exp_q.size() != 0) e = exp_q.pop_front();
                  end
               end else begin
                  check("strobes_in_resp", 64'(strb), 64'(0));
                  check("latency", 64'(cyc - acc_cyc), 64'(cur.lat));
                  if (exp_q.size() == 0) begin
                     check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                  end else begin
                     e = exp_q.pop_front();
                     check("rsp_err_m2r_rdata", 64'({rsp_err, mem_to_reg, rsp_rdata}), 64'(e));
                  end
                  in_flight = 1'b0;
               end
            end else begin
               check("no_rsp_when_idle", 64'(rsp_valid), 64'(0));
               check("idle_strobes", 64'(strb), 64'(0));
            end
            if (req_valid && req_ready) begin
               if (acc_q.size() == 0) begin
                  check("accept_unexpected", 64'(req_valid && req_ready), 64'(0));
               end else begin
                  cur       = acc_q.pop_front();
                  acc_cyc   = cyc;
                  in_flight = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int n;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b0;
      @(negedge clock);
      check("rst_req_ready", 64'(req_ready), 64'(1));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_err", 64'(rsp_err), 64'(0));
      check("rst_mem_to_reg", 64'(mem_to_reg), 64'(0));
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      check("rst_strobes", 64'({mem_read, mem_write, io_read, io_write}), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      check("rst_latched", 64'({mem_addr, mem_wdata}), 64'(0));
      @(posedge clock);
      #2;

      // memory load with known contents
      ref_mem[32'h0000_0040] = 32'hDEAD_BEEF;
      env_mem[32'h0000_0040] = 32'hDEAD_BEEF;
      issue(1'b0, 32'h0000_0040, '0, 0, 1'b0);
      idle(3);
      // I/O store to channel 1, ready on the third wait cycle
      issue(1'b1, 32'hFFFF_FC64, 32'h1234_5678, 3, 1'b0);
      idle(3);
      // I/O load to channel 2 that never completes
      issue(1'b0, 32'hFFFF_FC08, '0, NEVER, 1'b0);
      idle(3);
      // back-to-back with req_valid held: lw, sw, then read back the store
      issue(1'b0, 32'h0000_0080, '0, 0, 1'b1);
      issue(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 0, 1'b1);
      issue(1'b0, 32'h0000_0080, '0, 0, 1'b0);
      idle(2);
      // reset in the middle of an I/O wait
      issue(1'b0, 32'hFFFF_FC04, '0, NEVER, 1'b0);
      repeat (4) @(posedge clock);
      #2;
      reset = 1'b1;
      @(posedge clock);
      #2;
      reset = 1'b0;
      idle(3);
      // channel 3 with noise on other channels; ready on the timeout cycle
      issue(1'b0, 32'hFFFF_FC0C, '0, TMO, 1'b0);
      idle(2);
      issue(1'b1, 32'hFFFF_FC0C, 32'h0BAD_F00D, 2, 1'b0);
      // region boundary: last memory word below the I/O window, first I/O word
      issue(1'b0, 32'hFFFF_FBFC, '0, 0, 1'b0);
      issue(1'b0, 32'hFFFF_FC00, '0, 1, 1'b0);
      idle(2);

      for (int i = 0; i < 80; i++) begin
         logic        we;
         logic        hold;
         logic [31:0] a;
         int          w;
         int          r;
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) a = {IO_HI, 10'($urandom())};
         else                           a = pool[$urandom_range(0, 7)];
         r = $urandom_range(0, 9);
         w = (r == 0) ? NEVER : (r == 1) ? TMO : $urandom_range(1, 5);
         hold = (i < 79) && ($urandom_range(0, 2) == 0);
         issue(we, a, DATA_W'($urandom()), w, hold);
         if (!hold && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      end
      idle(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
